// File: rtl/rtype_core_pkg.sv
// Shared types and constants for the multi-cycle R-type core.
package rtype_core_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned FUNCT_W = 6;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT} alu_op_t;

  localparam logic [FUNCT_W-1:0] OPCODE_RTYPE = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD    = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB    = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_AND    = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR     = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR    = 6'h27;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT    = 6'h2A;

  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef struct packed {
    logic    legal;
    alu_op_t op;
  } funct_dec_t;

  // Map a funct field onto an ALU operation; unknown codes come back not legal.
  function automatic funct_dec_t decode_funct(input logic [FUNCT_W-1:0] funct);
    funct_dec_t d;
    d.legal = 1'b1;
    d.op    = ALU_ADD;
    case (funct)
      FUNCT_ADD: d.op = ALU_ADD;
      FUNCT_SUB: d.op = ALU_SUB;
      FUNCT_AND: d.op = ALU_AND;
      FUNCT_OR:  d.op = ALU_OR;
      FUNCT_NOR: d.op = ALU_NOR;
      FUNCT_SLT: d.op = ALU_SLT;
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rtype_alu.sv
// Combinational ALU shared by every instruction of the multi-cycle core.
module rtype_alu
  import rtype_core_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result_c
);

  always_comb begin
    result_c = '0;
    case (op)
      ALU_ADD: result_c = a + b;
      ALU_SUB: result_c = a - b;
      ALU_AND: result_c = a & b;
      ALU_OR:  result_c = a | b;
      ALU_NOR: result_c = ~(a | b);
      ALU_SLT: result_c = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/rtype_multicycle_core.sv
// Multi-cycle R-type core: fetch/decode/execute/writeback over one ALU and register file,
// with start/halt control, illegal-instruction trap, debug preload and writeback observation.
module rtype_multicycle_core
  import rtype_core_pkg::*;
#(
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned REG_NUM    = 32,
  parameter  int unsigned IMEM_DEPTH = 256,
  parameter  int unsigned PC_STEP    = 4,
  localparam int unsigned RA_W       = $clog2(REG_NUM),
  localparam int unsigned IA_W       = $clog2(IMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  output logic [IA_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               dbg_we,
  input  logic [RA_W-1:0]    dbg_addr,
  input  logic [DATA_W-1:0]  dbg_wdata,
  output logic               wb_valid,
  output logic [RA_W-1:0]    wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic [DATA_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               err
);

  state_t              state;
  logic [INSTR_W-1:0]  instr;
  logic [DATA_W-1:0]   rf [REG_NUM];
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic [DATA_W-1:0]   alu_q;
  logic [DATA_W-1:0]   alu_y;
  logic [DATA_W-1:0]   pc_next;
  logic [RA_W-1:0]     rd_q;
  alu_op_t             op_q;

  logic [RA_W-1:0]     rs;
  logic [RA_W-1:0]     rt;
  logic [RA_W-1:0]     rd;
  funct_dec_t          dec;
  logic                is_halt;
  logic                is_legal;

  // Field extraction from the latched instruction word.
  always_comb begin
    rs       = RA_W'(instr[25:21]);
    rt       = RA_W'(instr[20:16]);
    rd       = RA_W'(instr[15:11]);
    dec      = decode_funct(instr[5:0]);
    is_halt  = (instr == HALT_WORD);
    is_legal = (instr[31:26] == OPCODE_RTYPE) && dec.legal;
  end

  assign pc_next = pc + DATA_W'(PC_STEP);

  rtype_alu #(.DATA_W(DATA_W)) u_alu (
    .op       (op_q),
    .a        (op_a),
    .b        (op_b),
    .result_c (alu_y)
  );

  // Sequencer, register file and registered outputs. r0 is never written, so it reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
      instr     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      alu_q     <= '0;
      rd_q      <= '0;
      op_q      <= ALU_ADD;
      for (int unsigned i = 0; i < REG_NUM; i++) rf[i] <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE, HALT: begin
          if (dbg_we && (dbg_addr != '0)) rf[dbg_addr] <= dbg_wdata;
          if (start) begin
            pc        <= '0;
            halted    <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b1;
            imem_req  <= 1'b1;
            imem_addr <= '0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (imem_valid) begin
            instr    <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          op_a <= rf[rs];
          op_b <= rf[rt];
          rd_q <= rd;
          op_q <= dec.op;
          if (is_halt || !is_legal) begin
            busy   <= 1'b0;
            halted <= 1'b1;
            err    <= !is_halt;
            state  <= HALT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          alu_q <= alu_y;
          state <= WB;
        end
        WB: begin
          if (rd_q != '0) rf[rd_q] <= alu_q;
          wb_valid  <= 1'b1;
          wb_addr   <= rd_q;
          wb_data   <= alu_q;
          pc        <= pc_next;
          imem_req  <= 1'b1;
          imem_addr <= pc_next[IA_W+1:2];
          state     <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
